// File: rtl/ppu_writer.sv
// rtl/ppu_writer.sv - queued PPU table writer that drains committed commands during vertical blanking
module ppu_writer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_address,
    input  logic [31:0] cmd_data,
    input  logic        commit,
    input  logic        vblank,
    output logic        chipselect,
    output logic        write,
    output logic [11:0] address,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        drop_err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_VB, DRAIN} state_t;

    logic [43:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, pending_q, pending_d;
    state_t           state_q, state_d;
    logic             chipselect_q, chipselect_d;
    logic             write_q, write_d;
    logic [11:0]      address_q, address_d;
    logic [31:0]      writedata_q, writedata_d;
    logic             busy_q, busy_d;
    logic             drop_err_q, drop_err_d;

    logic        push, pop, head_drop;
    logic [43:0] head;

    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == DRAIN) && vblank && (pending_q != '0);
    assign head       = fifo_q[rd_ptr_q];
    assign head_drop  = (head[43:42] == 2'b11);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_address, cmd_data};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        // A commit releases everything present after this cycle's push/pop.
        pending_d    = commit ? count_d : (pending_q - CNT_W'(pop));
        chipselect_d = pop && !head_drop;
        write_d      = pop && !head_drop;
        address_d    = (pop && !head_drop) ? head[43:32] : address_q;
        writedata_d  = (pop && !head_drop) ? head[31:0]  : writedata_q;
        busy_d       = (pending_d != '0) || (pop && !head_drop);
        drop_err_d   = drop_err_q || (pop && head_drop);
        state_d      = state_q;
        case (state_q)
            IDLE:    if (pending_q != '0) state_d = WAIT_VB;
            WAIT_VB: if (vblank) state_d = DRAIN;
            DRAIN: begin
                if (pending_d == '0)  state_d = IDLE;
                else if (!vblank)     state_d = WAIT_VB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_q    <= '0;
            state_q      <= IDLE;
            chipselect_q <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            busy_q       <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
            chipselect_q <= chipselect_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            busy_q       <= busy_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign chipselect = chipselect_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign busy       = busy_q;
    assign drop_err   = drop_err_q;
endmodule
